// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if: bundles the request/mask/enable inputs and the interrupt,
// cause and acknowledge outputs of the priority interrupt controller.
//   irq_req_i   per-source request (pulse or level)
//   mask_i      per-source enable, 1 = enabled
//   mie_i       global interrupt enable
//   irq_ret_i   one-cycle return pulse from the core
//   irq_o       one-cycle interrupt pulse to the core
//   irq_cause_o cause code of the in-service interrupt
//   irq_ret_o   one-hot, one-cycle acknowledge to the serviced source
interface irq_ctrl_if #(
  parameter int N_SRC = 16
);
  logic [N_SRC-1:0] irq_req_i;
  logic [N_SRC-1:0] mask_i;
  logic             mie_i;
  logic             irq_ret_i;
  logic             irq_o;
  logic [31:0]      irq_cause_o;
  logic [N_SRC-1:0] irq_ret_o;

  // Controller side
  modport slave (
    input  irq_req_i, mask_i, mie_i, irq_ret_i,
    output irq_o, irq_cause_o, irq_ret_o
  );

  // Peripheral / core side
  modport master (
    output irq_req_i, mask_i, mie_i, irq_ret_i,
    input  irq_o, irq_cause_o, irq_ret_o
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: fixed-priority interrupt controller. Latches per-source
// requests, masks them, claims the lowest-index eligible source, pulses
// irq_o with an mcause-style code and acknowledges the source on return.
//   clk_i  system clock
//   rst_i  synchronous active-high reset
//   bus    irq_ctrl_if.slave (requests, masks, enables, return / irq,
//          cause, acknowledge)
//
// state | meaning
// IDLE  | no source in service; claims when mie_i=1 and an eligible source
// BUSY  | source r_cur_id in service; waits for irq_ret_i
module irq_ctrl #(
  parameter int N_SRC = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  irq_ctrl_if.slave  bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  state_t           r_state;
  logic [N_SRC-1:0] r_pending;
  logic [3:0]       r_cur_id;
  logic             r_irq;
  logic [31:0]      r_cause;
  logic [N_SRC-1:0] r_ret;

  logic [N_SRC-1:0] w_elig;
  logic [3:0]       w_id;
  logic             w_claim;
  logic [N_SRC-1:0] w_clr;

  always_comb begin
    w_elig = r_pending & bus.mask_i;
    w_id   = 4'd0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_id = 4'(i);
    end
    w_claim = (r_state == IDLE) && bus.mie_i && (|w_elig);
    w_clr   = w_claim ? (ONE << w_id) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_cur_id  <= 4'd0;
      r_irq     <= 1'b0;
      r_cause   <= 32'h0;
      r_ret     <= '0;
    end else begin
      r_irq     <= 1'b0;
      r_ret     <= '0;
      // A new request on the claimed source survives its own claim.
      r_pending <= (r_pending & ~w_clr) | bus.irq_req_i;
      case (r_state)
        IDLE: begin
          if (w_claim) begin
            r_state  <= BUSY;
            r_cur_id <= w_id;
            r_irq    <= 1'b1;
            r_cause  <= 32'h8000_0010 + {28'd0, w_id};
          end
        end
        BUSY: begin
          if (bus.irq_ret_i) begin
            r_state <= IDLE;
            r_ret   <= ONE << r_cur_id;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.irq_o       = r_irq;
  assign bus.irq_cause_o = r_cause;
  assign bus.irq_ret_o   = r_ret;
endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_ctrl_if #(.N_SRC(N)) bus();
  irq_ctrl #(.N_SRC(N)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Reference model: a set of pending sources, an optional in-service id.
  bit [N-1:0] m_pend;
  bit         m_busy;
  int         m_cur;
  bit         m_irq;
  bit [31:0]  m_cause;
  bit [N-1:0] m_ret;
  bit         prev_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int claim_id;
    if (rst) begin
      m_pend = '0; m_busy = 0; m_cur = 0;
      m_irq = 0; m_cause = 32'h0; m_ret = '0;
      return;
    end
    m_irq = 0;
    m_ret = '0;
    claim_id = -1;
    if (!m_busy && bus.mie_i) begin
      for (int i = 0; i < N; i++) begin
        if (m_pend[i] && bus.mask_i[i]) begin
          claim_id = i;
          break;
        end
      end
    end
    if (m_busy && bus.irq_ret_i) begin
      m_ret[m_cur] = 1'b1;
      m_busy = 0;
    end
    if (claim_id >= 0) begin
      m_busy = 1;
      m_cur = claim_id;
      m_pend[claim_id] = 1'b0;
      m_irq = 1;
      m_cause = 32'h8000_0010 + claim_id;
    end
    m_pend = m_pend | bus.irq_req_i;
  endtask

  // Apply current inputs across one rising edge, then compare against model.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("irq_o", {31'd0, bus.irq_o}, {31'd0, m_irq});
    chk("irq_cause_o", bus.irq_cause_o, m_cause);
    chk("irq_ret_o", {16'd0, bus.irq_ret_o}, {16'd0, m_ret});
    chk("irq_consecutive", {31'd0, prev_irq & bus.irq_o}, 32'd0);
    prev_irq = bus.irq_o;
  endtask

  task automatic set_in(input logic r, input logic [N-1:0] req, input logic [N-1:0] msk,
                        input logic mie, input logic ret);
    rst = r; bus.irq_req_i = req; bus.mask_i = msk; bus.mie_i = mie; bus.irq_ret_i = ret;
  endtask

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic [15:0] mask;
    logic        mie;
    logic        ret;
    logic        exp_irq;
    logic [31:0] exp_cause;
    logic [15:0] exp_ret;
  } vec_t;

  vec_t tbl[19];
  int irq_count;

  initial begin
    prev_irq = 0;
    set_in(1, '0, '0, 0, 0);
    //            rst  req      mask     mie ret  irq cause          ret
    tbl[0]  = '{1'b1, 16'h0000, 16'h0000, 0, 0, 0, 32'h0,          16'h0000};
    tbl[1]  = '{1'b1, 16'h0000, 16'h0000, 0, 0, 0, 32'h0,          16'h0000};
    tbl[2]  = '{1'b0, 16'h0000, 16'h0001, 1, 0, 0, 32'h0,          16'h0000};
    tbl[3]  = '{1'b0, 16'h0001, 16'h0001, 1, 0, 0, 32'h0,          16'h0000};
    tbl[4]  = '{1'b0, 16'h0000, 16'h0001, 1, 0, 1, 32'h8000_0010,  16'h0000};
    tbl[5]  = '{1'b0, 16'h0000, 16'h0001, 1, 0, 0, 32'h8000_0010,  16'h0000};
    tbl[6]  = '{1'b0, 16'h0000, 16'h0001, 1, 0, 0, 32'h8000_0010,  16'h0000};
    tbl[7]  = '{1'b0, 16'h0000, 16'h0001, 1, 0, 0, 32'h8000_0010,  16'h0000};
    tbl[8]  = '{1'b0, 16'h0000, 16'h0001, 1, 0, 0, 32'h8000_0010,  16'h0000};
    tbl[9]  = '{1'b0, 16'h0000, 16'h0001, 1, 1, 0, 32'h8000_0010,  16'h0001};
    tbl[10] = '{1'b0, 16'h0000, 16'hFFFF, 1, 0, 0, 32'h8000_0010,  16'h0000};
    tbl[11] = '{1'b0, 16'h000A, 16'hFFFF, 1, 0, 0, 32'h8000_0010,  16'h0000};
    tbl[12] = '{1'b0, 16'h0000, 16'hFFFF, 1, 0, 1, 32'h8000_0011,  16'h0000};
    tbl[13] = '{1'b0, 16'h0000, 16'hFFFF, 1, 0, 0, 32'h8000_0011,  16'h0000};
    tbl[14] = '{1'b0, 16'h0000, 16'hFFFF, 1, 1, 0, 32'h8000_0011,  16'h0002};
    tbl[15] = '{1'b0, 16'h0000, 16'hFFFF, 1, 0, 1, 32'h8000_0013,  16'h0000};
    tbl[16] = '{1'b0, 16'h0000, 16'hFFFF, 1, 0, 0, 32'h8000_0013,  16'h0000};
    tbl[17] = '{1'b0, 16'h0000, 16'hFFFF, 1, 1, 0, 32'h8000_0013,  16'h0008};
    tbl[18] = '{1'b0, 16'h0000, 16'hFFFF, 1, 0, 0, 32'h8000_0013,  16'h0000};

    @(negedge clk);
    for (int v = 0; v < 19; v++) begin
      set_in(tbl[v].rst, tbl[v].req, tbl[v].mask, tbl[v].mie, tbl[v].ret);
      step();
      chk($sformatf("tbl%0d_irq", v), {31'd0, bus.irq_o}, {31'd0, tbl[v].exp_irq});
      chk($sformatf("tbl%0d_cause", v), bus.irq_cause_o, tbl[v].exp_cause);
      chk($sformatf("tbl%0d_ret", v), {16'd0, bus.irq_ret_o}, {16'd0, tbl[v].exp_ret});
      if (v == 1) chk("reset_pending", {16'd0, dut.r_pending}, 32'd0);
    end

    // Masked source: no interrupt for 20 cycles, then unmask.
    set_in(0, 16'h0004, 16'h0000, 1, 0); step();
    bus.irq_req_i = '0;
    irq_count = 0;
    for (int c = 0; c < 20; c++) begin step(); irq_count += bus.irq_o; end
    chk("masked_no_irq", irq_count, 0);
    bus.mask_i = 16'h0004; step();
    chk("unmask_irq", {31'd0, bus.irq_o}, 32'd1);
    chk("unmask_cause", bus.irq_cause_o, 32'h8000_0012);
    step(); step();
    bus.irq_ret_i = 1; step(); bus.irq_ret_i = 0;
    chk("unmask_ack", {16'd0, bus.irq_ret_o}, 32'h0004);

    // Global enable off: pending held until mie_i returns.
    bus.mask_i = 16'hFFFF; bus.mie_i = 0; bus.irq_req_i = 16'h0004; step();
    bus.irq_req_i = '0;
    irq_count = 0;
    for (int c = 0; c < 20; c++) begin step(); irq_count += bus.irq_o; end
    chk("mie_off_no_irq", irq_count, 0);
    bus.mie_i = 1; step();
    chk("mie_on_irq", {31'd0, bus.irq_o}, 32'd1);
    chk("mie_on_cause", bus.irq_cause_o, 32'h8000_0012);
    bus.irq_ret_i = 1; step(); bus.irq_ret_i = 0; step();

    // Busy blocking: level request on source 0 while source 0 is in service.
    bus.irq_req_i = 16'h0001; step(); step();
    chk("busy_first_irq", {31'd0, bus.irq_o}, 32'd1);
    irq_count = 0;
    for (int c = 0; c < 6; c++) begin step(); irq_count += bus.irq_o; end
    chk("busy_blocked", irq_count, 0);
    bus.irq_ret_i = 1; step(); bus.irq_ret_i = 0; bus.irq_req_i = '0;
    chk("busy_ack", {16'd0, bus.irq_ret_o}, 32'h0001);
    step();
    chk("reclaim_irq", {31'd0, bus.irq_o}, 32'd1);
    chk("reclaim_cause", bus.irq_cause_o, 32'h8000_0010);
    bus.irq_ret_i = 1; step(); step();
    chk("ret_in_idle", {16'd0, bus.irq_ret_o}, 32'd0);
    bus.irq_ret_i = 0; step();

    // Reset while busy with source 5.
    bus.irq_req_i = 16'h0020; step(); bus.irq_req_i = '0; step();
    chk("src5_cause", bus.irq_cause_o, 32'h8000_0015);
    rst = 1; step(); rst = 0;
    chk("rst_busy_cause", bus.irq_cause_o, 32'h0);
    chk("rst_busy_pending", {16'd0, dut.r_pending}, 32'd0);
    bus.irq_ret_i = 1; step(); bus.irq_ret_i = 0;
    chk("rst_busy_no_ack", {16'd0, bus.irq_ret_o}, 32'd0);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.irq_req_i = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom & $urandom) : 16'h0;
      if ($urandom_range(0, 31) == 0) bus.mask_i = 16'($urandom | $urandom);
      if ($urandom_range(0, 15) == 0) bus.mie_i = ($urandom_range(0, 3) != 0);
      bus.irq_ret_i = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
